// File: rtl/mem_copy_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_dma_if
//  Description : Command and memory-port bundle for the byte copy/fill engine.
//                The slave side is the engine; the master side is whoever
//                issues commands and owns the memory returning read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_copy_dma_if;
    // Command side
    logic        start;
    logic        fill;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  pattern;
    logic        busy;
    logic        done;

    // Memory port side
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;

    modport master (
        output start, fill, src, dst, len, pattern, dread_data,
        input  busy, done, dread_addr, dwrite_addr, dwrite_data, dwrite_en
    );

    modport slave (
        input  start, fill, src, dst, len, pattern, dread_data,
        output busy, done, dread_addr, dwrite_addr, dwrite_data, dwrite_en
    );
endinterface
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_dma
//  Description : Memory-port initiator that copies or fills a byte range at
//                two bytes per cycle. Copy reads are fully pipelined: the
//                write for chunk i shares a cycle with the read for chunk i+2.
//                Odd-length tails use a single byte enable.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_copy_dma (
    input  logic          clk,
    input  logic          reset_n,
    mem_copy_dma_if.slave bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_COPY  = 3'd1;
    localparam logic [2:0] C_DRAIN = 3'd2;
    localparam logic [2:0] C_FILL  = 3'd3;
    localparam logic [2:0] C_DONE  = 3'd4;

    localparam logic [1:0] C_EN_BOTH = 2'b11;
    localparam logic [1:0] C_EN_LOW  = 2'b01;
    localparam logic [1:0] C_EN_NONE = 2'b00;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    // Read side: address on the port, and a flag saying it carries a read.
    logic [15:0] r_rd_addr;
    logic        r_rd_vld;
    logic        r_rd_last;

    // Data-return stage: dread_data is meaningful in the cycle after a read.
    logic        r_dat_vld;
    logic        r_dat_last;

    // Write side registers driven straight onto the port.
    logic [15:0] r_wr_addr;
    logic [15:0] r_wr_data;
    logic [1:0]  r_wr_en;

    // Next destination address to be written.
    logic [15:0] r_wr_ptr;

    // Chunks still to be issued after the one currently on the port.
    logic [15:0] r_cnt;

    // Latched low bit of len: the last chunk writes only one byte.
    logic        r_odd;

    logic        w_busy;
    logic        w_done;
    logic [15:0] w_chunks;
    logic        w_accept;
    logic [1:0]  w_first_fill_en;
    logic [1:0]  w_next_fill_en;
    logic [1:0]  w_copy_wr_en;

    // ceil(len/2) never exceeds 32768, so 16 bits are enough.
    assign w_chunks = {1'b0, bus.len[15:1]} + {15'd0, bus.len[0]};

    // A command with a non-zero length starts a memory operation.
    assign w_accept = (r_state == C_IDLE) && bus.start && (bus.len != 16'd0);

    assign w_first_fill_en = ((w_chunks == 16'd1) && bus.len[0]) ? C_EN_LOW : C_EN_BOTH;
    assign w_next_fill_en  = ((r_cnt == 16'd1) && r_odd) ? C_EN_LOW : C_EN_BOTH;
    assign w_copy_wr_en    = (r_dat_last && r_odd) ? C_EN_LOW : C_EN_BOTH;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Hold the current FSM state; reset drops any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Sequence IDLE -> COPY/DRAIN or FILL -> DONE -> IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE: begin
                if (bus.start) begin
                    if (bus.len == 16'd0) begin
                        w_next_state = C_DONE;
                    end else if (bus.fill) begin
                        w_next_state = C_FILL;
                    end else begin
                        w_next_state = C_COPY;
                    end
                end
            end
            C_COPY: begin
                // The last read is on the port when no chunks remain.
                if (r_cnt == 16'd0) begin
                    w_next_state = C_DRAIN;
                end
            end
            C_DRAIN: begin
                // The last write is on the port once nothing is in the pipe.
                if (!r_rd_vld && !r_dat_vld) begin
                    w_next_state = C_DONE;
                end
            end
            C_FILL: begin
                if (r_cnt == 16'd0) begin
                    w_next_state = C_DONE;
                end
            end
            C_DONE: begin
                w_next_state = C_IDLE;
            end
            default: begin
                w_next_state = C_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    // Status flags decode directly from the registered state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            C_COPY, C_DRAIN, C_FILL: w_busy = 1'b1;
            C_DONE:                  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Issue reads/fill writes per chunk and move returned read data to the
    // write port one cycle after it arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr  <= 16'd0;
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
            r_dat_vld  <= 1'b0;
            r_dat_last <= 1'b0;
            r_wr_addr  <= 16'd0;
            r_wr_data  <= 16'd0;
            r_wr_en    <= C_EN_NONE;
            r_wr_ptr   <= 16'd0;
            r_cnt      <= 16'd0;
            r_odd      <= 1'b0;
        end else begin
            // Defaults: no read or write issued this cycle.
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
            r_wr_en    <= C_EN_NONE;

            // Read data returns one cycle after the address was presented.
            r_dat_vld  <= r_rd_vld;
            r_dat_last <= r_rd_vld & r_rd_last;

            if (w_accept) begin
                r_odd <= bus.len[0];
                r_cnt <= w_chunks - 16'd1;
                if (bus.fill) begin
                    // First fill write goes out in the cycle after start.
                    r_wr_addr <= bus.dst;
                    r_wr_data <= {bus.pattern, bus.pattern};
                    r_wr_en   <= w_first_fill_en;
                    r_wr_ptr  <= bus.dst + 16'd2;
                end else begin
                    // First read goes out in the cycle after start.
                    r_rd_addr <= bus.src;
                    r_rd_vld  <= 1'b1;
                    r_rd_last <= (w_chunks == 16'd1);
                    r_wr_ptr  <= bus.dst;
                end
            end else if (r_state == C_COPY) begin
                if (r_cnt != 16'd0) begin
                    r_rd_addr <= r_rd_addr + 16'd2;
                    r_rd_vld  <= 1'b1;
                    r_rd_last <= (r_cnt == 16'd1);
                    r_cnt     <= r_cnt - 16'd1;
                end
            end else if (r_state == C_FILL) begin
                if (r_cnt != 16'd0) begin
                    r_wr_addr <= r_wr_ptr;
                    r_wr_en   <= w_next_fill_en;
                    r_wr_ptr  <= r_wr_ptr + 16'd2;
                    r_cnt     <= r_cnt - 16'd1;
                end
            end

            // Copy writes: only active in COPY/DRAIN, never overlaps a fill.
            if (r_dat_vld) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= bus.dread_data;
                r_wr_en   <= w_copy_wr_en;
                r_wr_ptr  <= r_wr_ptr + 16'd2;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.dread_addr  = r_rd_addr;
    assign bus.dwrite_addr = r_wr_addr;
    assign bus.dwrite_data = r_wr_data;
    assign bus.dwrite_en   = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_dma
//  Description : Scoreboard bench for mem_copy_dma with a byte-array memory,
//                a byte-level reference model and randomized commands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_copy_dma;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_dma_if bus ();

    mem_copy_dma dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  en;
        int unsigned cyc;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    // Memory model: registered 2-byte read, byte-enabled write, load port.
    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] rd_q    = 16'd0;
    logic        ld_en   = 1'b0;
    logic [15:0] ld_addr = 16'd0;
    logic [7:0]  ld_data = 8'd0;
    logic [15:0] ra1;
    logic [15:0] wa1;

    assign ra1 = bus.dread_addr + 16'd1;
    assign wa1 = bus.dwrite_addr + 16'd1;
    assign bus.dread_data = rd_q;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_q <= {ram[ra1], ram[bus.dread_addr]};
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else begin
            if (bus.dwrite_en[0]) ram[bus.dwrite_addr] <= bus.dwrite_data[7:0];
            if (bus.dwrite_en[1]) ram[wa1] <= bus.dwrite_data[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every presented write is popped from the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (reset_n && bus.dwrite_en != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {14'd0, bus.dwrite_en, bus.dwrite_addr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr_data", {bus.dwrite_addr, bus.dwrite_data}, {e.addr, e.data});
                chk("wr_en", {30'd0, bus.dwrite_en}, {30'd0, e.en});
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Regions preloaded and compared against the reference after every command.
    int unsigned reg_base [7] = '{32'h1000, 32'h8000, 32'h3C00, 32'h3E00, 32'h3F00, 32'hFFF8, 32'h0000};
    int unsigned reg_len  [7] = '{256, 256, 16, 16, 8, 8, 8};

    task automatic load_byte(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        ref_mem[a] = v;
    endtask

    task automatic compare_mem(input string name);
        int unsigned bad;
        logic [15:0] a;
        bad = 0;
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < int'(reg_len[r]); i++) begin
                a = 16'(reg_base[r] + i);
                if (ram[a] !== ref_mem[a]) bad++;
            end
        end
        chk(name, bad, 0);
    endtask

    // Issue one command, model it at byte level and check its timing.
    task automatic run_cmd(input bit f, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [7:0] p, input bit inject);
        int          c;
        int          exp_done;
        int          busy_end;
        int unsigned t0;
        logic [15:0] ra0;
        logic [15:0] a;
        logic [15:0] b;
        logic        smp_busy;
        logic        smp_done;
        bit          got_done;

        c        = (int'(l) + 1) / 2;
        exp_done = (l == 16'd0) ? 1 : (f ? c + 1 : c + 3);
        busy_end = (l == 16'd0) ? 0 : (f ? c : c + 2);

        @(negedge clk);
        t0  = cyc;
        ra0 = bus.dread_addr;

        for (int i = 0; i < c; i++) begin
            wr_t w;
            w.addr = d + 16'(2 * i);
            a      = s + 16'(2 * i);
            b      = a + 16'd1;
            w.data = f ? {p, p} : {ref_mem[b], ref_mem[a]};
            w.en   = ((i == c - 1) && l[0]) ? 2'b01 : 2'b11;
            w.cyc  = t0 + (f ? 1 : 3) + i;
            exp_q.push_back(w);
        end
        for (int j = 0; j < int'(l); j++) begin
            a = d + 16'(j);
            b = s + 16'(j);
            ref_mem[a] = f ? p : ref_mem[b];
        end

        bus.start   = 1'b1;
        bus.fill    = f;
        bus.src     = s;
        bus.dst     = d;
        bus.len     = l;
        bus.pattern = p;

        got_done = 1'b0;
        for (int k = 1; k <= exp_done + 20; k++) begin
            @(negedge clk);
            smp_busy = bus.busy;
            smp_done = bus.done;
            if (k == 1) bus.start = 1'b0;
            if (inject && k == 2) begin
                bus.start = 1'b1;
                bus.fill  = ~f;
                bus.src   = 16'h1010;
                bus.dst   = 16'h8080;
                bus.len   = 16'd6;
            end
            if (inject && k == 3) bus.start = 1'b0;
            chk("busy", {31'd0, smp_busy}, {31'd0, (k <= busy_end) ? 1'b1 : 1'b0});
            if (smp_done) begin
                chk("done_cycle", k, exp_done);
                got_done = 1'b1;
                break;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);

        repeat (2) begin
            @(negedge clk);
            chk("done_single", {31'd0, bus.done}, 32'd0);
            chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        end
        chk("pending_writes", exp_q.size(), 0);
        if (f || l == 16'd0) chk("dread_addr_hold", {16'd0, bus.dread_addr}, {16'd0, ra0});
        compare_mem("mem_bytes_wrong");
    endtask

    // Start an 8-chunk copy and pull reset low in its fourth cycle.
    task automatic abort_copy();
        logic [15:0] s;
        logic [15:0] d;
        s = 16'h1020;
        d = 16'h8040;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            wr_t w;
            w.addr = d + 16'(2 * i);
            w.data = {ref_mem[s + 16'(2 * i + 1)], ref_mem[s + 16'(2 * i)]};
            w.en   = 2'b11;
            w.cyc  = cyc + 3 + i;
            exp_q.push_back(w);
        end
        bus.start = 1'b1;
        bus.fill  = 1'b0;
        bus.src   = s;
        bus.dst   = d;
        bus.len   = 16'd16;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            chk("abort_busy", {31'd0, bus.busy}, 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wr_en", {30'd0, bus.dwrite_en}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.delete();
        // Only chunk 0 (cycle 3) reached memory before reset.
        ref_mem[d]         = ref_mem[s];
        ref_mem[d + 16'd1] = ref_mem[s + 16'd1];
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", {31'd0, bus.done}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", {31'd0, bus.done}, 32'd0);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.fill    = 1'b0;
        bus.src     = 16'd0;
        bus.dst     = 16'd0;
        bus.len     = 16'd0;
        bus.pattern = 8'd0;

        repeat (2) @(negedge clk);
        chk("rst_busy0", {31'd0, bus.busy}, 32'd0);
        chk("rst_done0", {31'd0, bus.done}, 32'd0);
        chk("rst_dread_addr", {16'd0, bus.dread_addr}, 32'd0);
        chk("rst_dwrite_addr", {16'd0, bus.dwrite_addr}, 32'd0);
        chk("rst_dwrite_data", {16'd0, bus.dwrite_data}, 32'd0);
        chk("rst_dwrite_en", {30'd0, bus.dwrite_en}, 32'd0);

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < int'(reg_len[r]); i++) begin
                load_byte(16'(reg_base[r] + i), 8'($urandom));
            end
        end
        for (int i = 0; i < 8; i++) load_byte(16'h3C00 + 16'(i), 8'(i + 1));
        @(negedge clk);
        ld_en   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // Aligned copy of 01..08.
        run_cmd(1'b0, 16'h3C00, 16'h3E00, 16'd8, 8'h00, 1'b0);
        chk("aligned_word0", {16'd0, ram[16'h3E01], ram[16'h3E00]}, 32'h0201);
        chk("aligned_word3", {16'd0, ram[16'h3E07], ram[16'h3E06]}, 32'h0807);
        // Unaligned, odd-length copy.
        run_cmd(1'b0, 16'h3C01, 16'h3E03, 16'd5, 8'h00, 1'b0);
        chk("odd_last_byte", {24'd0, ram[16'h3E07]}, 32'h06);
        // Fill, odd length.
        run_cmd(1'b1, 16'h0000, 16'h3F00, 16'd3, 8'hA5, 1'b0);
        // Zero length.
        run_cmd(1'b0, 16'h1000, 16'h8000, 16'd0, 8'h00, 1'b0);
        // Fill across the top of the address space.
        run_cmd(1'b1, 16'h0000, 16'hFFFF, 16'd2, 8'h5A, 1'b0);
        chk("wrap_byte0", {24'd0, ram[16'h0000]}, 32'h5A);
        // Stray start while busy must be ignored.
        run_cmd(1'b0, 16'h1040, 16'h80A0, 16'd20, 8'h00, 1'b1);

        for (int n = 0; n < 20; n++) begin
            bit          f;
            logic [15:0] s;
            logic [15:0] d;
            logic [15:0] l;
            f = ($urandom_range(0, 3) == 0);
            s = 16'h1000 + 16'($urandom_range(0, 191));
            d = 16'h8000 + 16'($urandom_range(0, 191));
            l = 16'($urandom_range(0, 64));
            run_cmd(f, s, d, l, 8'($urandom), (n % 7) == 3);
        end

        abort_copy();
        run_cmd(1'b0, 16'h1003, 16'h80C1, 16'd13, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_copy_dma.md
# mem_copy_dma

- Memory-port initiator that copies or fills a byte range, driving the same read/write port bundle the CPU drives into the dual-bank `ram` block.
- Sits beside the CPU on that port and is arbitrated upstream (out of scope), e.g. for clearing BSS or relocating data at boot.
- Copies 2 bytes/cycle, fully pipelined, using byte write enables for odd-length tails; fill mode writes a repeated byte pattern without reading.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `fill`  in  1  0 = copy, 1 = fill; latched with `start`.
- `src`  in  16  source byte address (copy); latched.
- `dst`  in  16  destination byte address; latched.
- `len`  in  16  byte count, 0..65535; latched.
- `pattern`  in  8  fill byte; latched.
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle completion pulse.
- `dread_addr`  out  16  read byte address, registered.
- `dread_data`  in  16  read data, valid the cycle after `dread_addr` is presented; `[7:0]` = byte at addr, `[15:8]` = byte at addr+1, any alignment.
- `dwrite_addr`  out  16  write byte address, registered.
- `dwrite_data`  out  16  `[7:0]` = byte at addr, `[15:8]` = byte at addr+1, registered.
- `dwrite_en`  out  2  byte enables (bit0 → addr, bit1 → addr+1), registered.

## Operation
- Reset values: `busy`=0, `done`=0, `dread_addr`=0, `dwrite_addr`=0, `dwrite_data`=0, `dwrite_en`=2'b00, state IDLE. Reset is asynchronous and takes effect mid-command: pending writes are dropped and `dwrite_en` goes to 0 immediately.
- Chunk count C = ceil(len/2). Chunk i covers bytes base+2i and base+2i+1. All address arithmetic is 16-bit modulo, wrapping 0xFFFF→0x0000.
- States:
  - IDLE
    - `start`=1 with `len`=0: go DONE with no memory access.
    - `start`=1 with `len`≠0: latch operands; go COPY (`fill`=0) or FILL (`fill`=1).
  - COPY: each cycle present `dread_addr`=src+2i and increment i. After chunk C−1 is issued, go DRAIN.
  - Read pipeline: each returned `dread_data` is registered one cycle later onto `dwrite_data` with `dwrite_addr`=dst+2i.
    - `dwrite_en`=2'b11, except the final chunk of an odd `len`, which uses 2'b01.
    - The final chunk's read still fetches 2 bytes; the extra byte is discarded.
  - DRAIN: wait for the last write to leave the port, then go DONE.
  - FILL: each cycle write chunk i with `dwrite_data`={pattern,pattern} and the same enable rule. No reads are issued; `dread_addr` holds. After the last chunk, go DONE.
  - DONE: `done`=1 for exactly one cycle, `busy`=0, then return to IDLE.
- `busy` is high in COPY, DRAIN and FILL. `start` is ignored whenever state≠IDLE.
- `dwrite_en`=2'b00 in every cycle that carries no valid write.
- Overlap: forward copy is correct for dst ≤ src or for non-overlapping ranges. dst in (src, src+len) is a caller error: the command still terminates in the same cycle count, and the destination contents are unspecified.

## Timing
- Cycle 0: `start` sampled at its closing edge.
- Copy:
  - Reads are presented in cycles 1..C.
  - Writes are presented in cycles 3..C+2 (read-to-write latency 2).
  - `done` is high in cycle C+3.
  - `busy` is high in cycles 1..C+2.
- Fill: writes in cycles 1..C; `done` in cycle C+1; `busy` high in cycles 1..C.
- `len`=0: `done` in cycle 1; `busy` never asserted.
- Back-to-back commands: the earliest accepted `start` is in the DONE cycle + 1 (IDLE).
- Throughput: one 16-bit chunk per cycle, with no stalls.
- While a copy is in flight, the write for chunk i and the read for chunk i+2 share a cycle. For legal (non-dst>src-overlap) commands these never touch the same bytes.

## Test plan
- Copy, aligned: preload 0x3C00..0x3C07 = 01..08; src=0x3C00, dst=0x3E00, len=8.
  - Expect 4 writes of 0x0201, 0x0403, 0x0605, 0x0807 with en=11 at 0x3E00/02/04/06 in cycles 3–6.
  - Expect `done` in cycle 7; RAM 0x3E00..07 = 01..08.
- Copy, unaligned/odd: src=0x3C01, dst=0x3E03, len=5.
  - Expect 3 chunks; last write addr 0x3E07, en=01.
  - Expect 0x3E08 unchanged and 0x3E03..07 = 02..06.
- Fill: `fill`=1, dst=0x3F00, len=3, `pattern`=0xA5.
  - Expect writes (0x3F00, 0xA5A5, 11) in cycle 1 and (0x3F02, 0xA5A5, 01) in cycle 2.
  - Expect `done` in cycle 3; no change on `dread_addr`.
- Boundaries:
  - `len`=0 gives `done` in cycle 1 with no writes.
  - dst=0xFFFF, fill, len=2 gives a single write at 0xFFFF covering 0xFFFF and the byte at the next address (0x0000, via the RAM's addr+1).
  - A second `start` while busy is ignored; `done` pulses exactly once.
- Reset mid-copy: assert `reset_n`=0 in cycle 4 of an 8-chunk copy.
  - `dwrite_en`=00 and `busy`=0 immediately.
  - No `done` pulse.
  - A new command after release completes normally.
